data_memory_ws: RTL and testbench

DATA_MEMORY_WS -- requirements
Module: data_memory_ws

---
 rtl/data_memory_ws.sv | 118 +++++++++++
 tb/tb_data_memory_ws.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_ws.sv
// Word-addressed data memory with a fixed wait-state handshake and address-range checking.
// States: IDLE | ready for a new request (completes at once when WAIT_CYCLES=0); WAIT | counting wait states on captured request
module data_memory_ws #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] data_memory_out,
    output logic                  ready,
    output logic                  addr_err
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] BASE      = 32'(BASE_ADDR);
    localparam logic [32:0] LIMIT     = 33'(BASE_ADDR) + 33'(4 * DEPTH);
    localparam logic [3:0]  WC        = 4'(WAIT_CYCLES);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req;
    logic                  abort;
    logic                  done;
    logic                  cmp_write;
    logic [31:0]           cmp_addr;
    logic [DATA_WIDTH-1:0] cmp_data;
    logic [31:0]           offset;
    logic [AW-1:0]         idx;
    logic                  cmp_valid;
    logic [DATA_WIDTH-1:0] rd_word;

    assign req   = mem_r_en | mem_w_en;
    assign abort = (state == WAIT) && !req;

    // Zero-wait accesses complete from the live inputs; otherwise the captured request is used.
    always_comb begin
        done      = 1'b0;
        cmp_write = mem_w_en;
        cmp_addr  = address;
        cmp_data  = data;
        if (state == IDLE) begin
            done = req && ZERO_WAIT;
        end else begin
            done      = req && (cnt == WC);
            cmp_write = req_write;
            cmp_addr  = req_addr;
            cmp_data  = req_data;
        end
        if (rst) begin
            done = 1'b0;
        end
    end

    assign offset    = cmp_addr - BASE;
    assign idx       = AW'(offset >> 2);
    assign cmp_valid = ({1'b0, cmp_addr} >= {1'b0, BASE}) && ({1'b0, cmp_addr} < LIMIT) &&
                       (cmp_addr[1:0] == 2'b00);
    assign rd_word   = cmp_valid ? mem[idx] : '0;

    assign ready           = rst || ((state == IDLE) ? (!req || ZERO_WAIT) : (abort || done));
    assign addr_err        = done && !cmp_valid;
    assign data_memory_out = (done && !cmp_write) ? rd_word : hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
            hold      <= '0;
        end else begin
            if (done && !cmp_write) begin
                hold <= rd_word;
            end
            case (state)
                IDLE: begin
                    if (req && !ZERO_WAIT) begin
                        state     <= WAIT;
                        cnt       <= 4'd1;
                        req_write <= mem_w_en;
                        req_addr  <= address;
                        req_data  <= data;
                    end
                end
                WAIT: begin
                    if (abort || done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Array contents survive reset; writes are gated off by reset through done.
    always_ff @(posedge clk) begin
        if (done && cmp_write && cmp_valid) begin
            mem[idx] <= cmp_data;
        end
    end
endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: one instance with 3 wait states, one with none.
module tb_data_memory_ws;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, r_en, w_en, rdy, err;
    logic [31:0] addr, wdata, dout;
    logic        rst0, r_en0, w_en0, rdy0, err0;
    logic [31:0] addr0, wdata0, dout0;

    int n_chk  = 0;
    int n_fail = 0;

    data_memory_ws #(.WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en), .address(addr),
        .data(wdata), .data_memory_out(dout), .ready(rdy), .addr_err(err)
    );

    data_memory_ws #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .mem_r_en(r_en0), .mem_w_en(w_en0), .address(addr0),
        .data(wdata0), .data_memory_out(dout0), .ready(rdy0), .addr_err(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full 4-cycle access on the wait-state instance; checks ready each cycle and the completion outputs.
    task automatic acc(input string tag, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err, input logic [31:0] exp_out);
        w_en  = w;
        r_en  = r;
        addr  = a;
        wdata = d;
        for (int c = 1; c <= 4; c++) begin
            #2;
            check({tag, "_ready"}, {31'b0, rdy}, {31'b0, (c == 4)});
            if (c == 4) begin
                check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
                check({tag, "_out"}, dout, exp_out);
            end
            step();
        end
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; r_en = 1'b0; w_en = 1'b0; addr = '0; wdata = '0;
        rst0 = 1'b1; r_en0 = 1'b0; w_en0 = 1'b0; addr0 = '0; wdata0 = '0;
        step();
        step();
        rst  = 1'b0;
        rst0 = 1'b0;
        #2;
        check("rst_ready", {31'b0, rdy}, 32'd1);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_out", dout, 32'd0);
        check("rst0_out", dout0, 32'd0);
        step();

        acc("wr1024", 1'b1, 1'b0, 32'd1024, 32'h1111_1111, 1'b0, 32'h0);
        acc("wr1032", 1'b1, 1'b0, 32'd1032, 32'hAAAA_5555, 1'b0, 32'h0);
        acc("wr1036", 1'b1, 1'b0, 32'd1036, 32'h3636_3636, 1'b0, 32'h0);
        acc("wr1028", 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 1'b0, 32'h0);
        acc("rd1028", 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 32'hDEAD_BEEF);
        #2;
        check("hold1028", dout, 32'hDEAD_BEEF);
        step();

        // Out-of-range and misaligned accesses
        acc("rd1020", 1'b0, 1'b1, 32'd1020, 32'h0, 1'b1, 32'h0);
        acc("rd1280", 1'b0, 1'b1, 32'd1280, 32'h0, 1'b1, 32'h0);
        acc("rd1026", 1'b0, 1'b1, 32'd1026, 32'h0, 1'b1, 32'h0);
        acc("wr1280", 1'b1, 1'b0, 32'd1280, 32'hBADB_AD00, 1'b1, 32'h0);
        acc("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'h1111_1111);

        // Abort: both enables dropped in the second cycle
        w_en = 1'b1; addr = 32'd1032; wdata = 32'h1234_5678;
        #2;
        check("abort_c1_ready", {31'b0, rdy}, 32'd0);
        step();
        w_en = 1'b0;
        #2;
        check("abort_ready", {31'b0, rdy}, 32'd1);
        check("abort_err", {31'b0, err}, 32'd0);
        check("abort_out", dout, 32'h1111_1111);
        step();
        acc("rd1032", 1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 32'hAAAA_5555);

        // Reset in the second cycle of a write
        w_en = 1'b1; addr = 32'd1036; wdata = 32'h0BAD_F00D;
        #2;
        check("rstw_c1_ready", {31'b0, rdy}, 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; w_en = 1'b0;
        #2;
        check("rstw_ready", {31'b0, rdy}, 32'd1);
        check("rstw_out", dout, 32'd0);
        check("rstw_err", {31'b0, err}, 32'd0);
        step();
        acc("rd1036", 1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, 32'h3636_3636);

        // Address changes during WAIT must not affect the captured request
        r_en = 1'b1; addr = 32'd1028;
        #2;
        check("stab_c1_ready", {31'b0, rdy}, 32'd0);
        step();
        addr = 32'd1281;
        #2;
        check("stab_c2_ready", {31'b0, rdy}, 32'd0);
        step();
        addr = 32'd1024;
        #2;
        check("stab_c3_ready", {31'b0, rdy}, 32'd0);
        step();
        #2;
        check("stab_ready", {31'b0, rdy}, 32'd1);
        check("stab_err", {31'b0, err}, 32'd0);
        check("stab_out", dout, 32'hDEAD_BEEF);
        step();
        r_en = 1'b0;

        // Simultaneous read and write performs only the write
        acc("rw1024", 1'b1, 1'b1, 32'd1024, 32'h5A5A_5A5A, 1'b0, 32'hDEAD_BEEF);
        #2;
        check("rw_hold", dout, 32'hDEAD_BEEF);
        step();
        acc("rd1024b", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'h5A5A_5A5A);

        // Back-to-back reads with the enable held high
        r_en = 1'b1; addr = 32'd1032;
        for (int c = 1; c <= 8; c++) begin
            #2;
            check("b2b_ready", {31'b0, rdy}, {31'b0, (c % 4 == 0)});
            if (c % 4 == 0) check("b2b_out", dout, 32'hAAAA_5555);
            step();
        end
        r_en = 1'b0;

        // Zero wait states, last word of the array
        w_en0 = 1'b1; addr0 = 32'd1276; wdata0 = 32'h7676_7676;
        #2;
        check("zw_wr_ready", {31'b0, rdy0}, 32'd1);
        check("zw_wr_err", {31'b0, err0}, 32'd0);
        step();
        w_en0 = 1'b0; r_en0 = 1'b1;
        #2;
        check("zw_rd_ready", {31'b0, rdy0}, 32'd1);
        check("zw_rd_out", dout0, 32'h7676_7676);
        check("zw_rd_err", {31'b0, err0}, 32'd0);
        step();
        r_en0 = 1'b0;
        #2;
        check("zw_hold", dout0, 32'h7676_7676);
        step();
        r_en0 = 1'b1; addr0 = 32'd1280;
        #2;
        check("zw_bad_ready", {31'b0, rdy0}, 32'd1);
        check("zw_bad_err", {31'b0, err0}, 32'd1);
        check("zw_bad_out", dout0, 32'd0);
        step();
        r_en0 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
